// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the ROB-side memory controller.
//   mc_state_e  : controller FSM states
//   mem_width_e : access width encodings carried on the Width port
//   IO_ADDR*_DEF: default backpressured IO addresses
//   width_bytes : byte count for a width code (unused code 11 behaves as word)
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_width_e;

  localparam logic [31:0] IO_ADDR0_DEF = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR1_DEF = 32'h0003_0004;

  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    logic [2:0] n;
    if (w == MEM_B)      n = 3'd1;
    else if (w == MEM_H) n = 3'd2;
    else                 n = 3'd4;
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: responder side of the ROB memory interface. Takes one load/store
// at a time and serialises it into byte accesses on an 8-bit synchronous
// RAM/IO port, assembling and extending load data.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready; low freezes the block (mem_wr forced 0)
//   clr                 flush; aborts reads, blocks new reads in IDLE
//   RN, WN              read / write request (WN wins)
//   Addr, Wvalue        byte address, store data (low bytes first)
//   Width, Sign         00 byte / 01 half / 10,11 word; sign-extend loads
//   Mem_Success         one-cycle completion pulse
//   Read_Value          load result, valid with Mem_Success
//   mem_din/mem_dout    RAM read / write byte
//   mem_a, mem_wr       RAM byte address, write strobe
//   io_buffer_full      blocks writes to IO_ADDR0 / IO_ADDR1
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR0 = ADDR_W'(IO_ADDR0_DEF),
  parameter logic [ADDR_W-1:0] IO_ADDR1 = ADDR_W'(IO_ADDR1_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              RN,
  input  logic              WN,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Wvalue,
  input  logic [1:0]        Width,
  input  logic              Sign,
  output logic              Mem_Success,
  output logic [31:0]       Read_Value,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  mc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        width_q, width_d;
  logic              sign_q, sign_d;
  logic [2:0]        n_q, n_d;          // active edges since accept
  logic [31:0]       data_q, data_d;    // captured load bytes
  logic [7:0]        skid_q, skid_d;
  logic              skid_v_q, skid_v_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              success_q, success_d;
  logic [31:0]       rval_q, rval_d;

  logic       io_hit, accept_wr, accept_rd;
  logic [2:0] k, k1, j, cap_idx;
  logic [7:0] cap_byte;

  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  w,
                                              input logic        sgn);
    logic [31:0] r;
    if (w == MEM_B)      r = {{24{sgn & raw[7]}}, raw[7:0]};
    else if (w == MEM_H) r = {{16{sgn & raw[15]}}, raw[15:0]};
    else                 r = raw;
    return r;
  endfunction

  assign io_hit    = (Addr == IO_ADDR0) || (Addr == IO_ADDR1);
  assign accept_wr = WN && !(io_hit && io_buffer_full);
  assign accept_rd = !WN && RN && !clr;

  assign k       = width_bytes(width_q);
  assign k1      = k + 3'd1;
  assign j       = n_q + 3'd1;
  assign cap_idx = j - 3'd2;
  // After a stall the byte in flight when rdy dropped sits in the skid.
  assign cap_byte = skid_v_q ? skid_q : mem_din;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= MC_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      unique case (state_q)
        MC_IDLE: begin
          if (accept_wr)      state_d = MC_WRITE;
          else if (accept_rd) state_d = MC_READ;
        end
        MC_READ: begin
          if (clr)          state_d = MC_IDLE;
          else if (j >= k1) state_d = MC_DONE;
        end
        MC_WRITE: if (j >= k) state_d = MC_DONE;
        MC_DONE:  state_d = MC_IDLE;
        default:  state_d = MC_IDLE;
      endcase
    end
  end

  // Output / datapath next-state logic
  always_comb begin
    base_d     = base_q;
    wdata_d    = wdata_q;
    width_d    = width_q;
    sign_d     = sign_q;
    n_d        = n_q;
    data_d     = data_q;
    skid_d     = skid_q;
    skid_v_d   = skid_v_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    success_d  = 1'b0;
    rval_d     = rval_q;
    if (!rdy) begin
      success_d = success_q;
      // The RAM keeps re-reading the held mem_a during the stall, so the byte
      // due at the next active edge is only on mem_din at the first stall edge.
      if (state_q == MC_READ && !skid_v_q && j >= 3'd2) begin
        skid_d   = mem_din;
        skid_v_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        MC_IDLE: begin
          if (accept_wr || accept_rd) begin
            base_d   = Addr;
            wdata_d  = Wvalue;
            width_d  = Width;
            sign_d   = Sign;
            n_d      = '0;
            data_d   = '0;
            skid_v_d = 1'b0;
            mem_a_d  = Addr;
            if (accept_wr) begin
              mem_dout_d = Wvalue[7:0];
              mem_wr_d   = 1'b1;
            end
          end
        end
        MC_READ: begin
          if (!clr) begin
            n_d = j;
            if (j < k) mem_a_d = base_q + ADDR_W'(j);
            if (j >= 3'd2) begin
              for (int unsigned b = 0; b < 4; b++) begin
                if (cap_idx == 3'(b)) data_d[8*b +: 8] = cap_byte;
              end
              skid_v_d = 1'b0;
            end
            if (j >= k1) begin
              success_d = 1'b1;
              rval_d    = extend_load(data_d, width_q, sign_q);
            end
          end
        end
        MC_WRITE: begin
          n_d = j;
          if (j < k) begin
            mem_a_d = base_q + ADDR_W'(j);
            for (int unsigned b = 0; b < 4; b++) begin
              if (j == 3'(b)) mem_dout_d = wdata_q[8*b +: 8];
            end
            mem_wr_d = 1'b1;
          end else begin
            success_d = 1'b1;
          end
        end
        MC_DONE: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      wdata_q    <= '0;
      width_q    <= '0;
      sign_q     <= 1'b0;
      n_q        <= '0;
      data_q     <= '0;
      skid_q     <= '0;
      skid_v_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      success_q  <= 1'b0;
      rval_q     <= '0;
    end else begin
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      width_q    <= width_d;
      sign_q     <= sign_d;
      n_q        <= n_d;
      data_q     <= data_d;
      skid_q     <= skid_d;
      skid_v_q   <= skid_v_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      success_q  <= success_d;
      rval_q     <= rval_d;
    end
  end

  assign Mem_Success = success_q;
  assign Read_Value  = rval_q;
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign mem_wr      = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed, table-driven bench for mem_ctrl with a small
// synchronous byte RAM (address sampled at an edge, data valid next cycle).
module tb_mem_ctrl;

  logic        clk, rst, rdy, clr, RN, WN, Sign, Mem_Success, mem_wr, io_buffer_full;
  logic [31:0] Addr, Wvalue, Read_Value, mem_a;
  logic [1:0]  Width;
  logic [7:0]  mem_din, mem_dout;
  logic [7:0]  ram [4096];
  int          errors, checks;

  typedef struct {
    logic        rn;
    logic        wn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] exp_val;
    int          exp_lat;
  } vec_t;

  vec_t vecs [13];

  mem_ctrl #(
    .ADDR_W  (32),
    .IO_ADDR0(32'h0003_0000),
    .IO_ADDR1(32'h0003_0004)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .clr           (clr),
    .RN            (RN),
    .WN            (WN),
    .Addr          (Addr),
    .Wvalue        (Wvalue),
    .Width         (Width),
    .Sign          (Sign),
    .Mem_Success   (Mem_Success),
    .Read_Value    (Read_Value),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, follow it to Mem_Success and check the byte stream.
  // stall_at: active-edge index after which rdy is dropped for stall_len edges.
  task automatic run_txn(input string tag, input vec_t v, input int stall_at, input int stall_len);
    int          k, lat, act, wrs, stalls;
    bit          last_active, seen;
    logic [31:0] ea;
    logic [31:0] wd;
    k = (v.width == 2'b00) ? 1 : (v.width == 2'b01) ? 2 : 4;
    RN = v.rn; WN = v.wn; Addr = v.addr; Wvalue = v.wdata; Width = v.width; Sign = v.sgn;
    tick();
    RN = 1'b0; WN = 1'b0;
    lat = 0; act = 0; wrs = 0; stalls = 0; last_active = 1'b1; seen = 1'b0;
    while (!seen && lat < 40) begin
      if (last_active && act < k) begin
        ea = v.addr + 32'(act);
        wd = v.wdata >> (8 * act);
        check($sformatf("%s mem_a[%0d]", tag, act), mem_a, ea);
        check($sformatf("%s mem_wr[%0d]", tag, act), 32'(mem_wr), 32'(v.wn));
        if (v.wn) check($sformatf("%s mem_dout[%0d]", tag, act), 32'(mem_dout), 32'(wd[7:0]));
      end
      if (mem_wr) wrs++;
      if (act == stall_at && stalls < stall_len) begin
        rdy = 1'b0;
        stalls++;
      end else begin
        rdy = 1'b1;
      end
      tick();
      lat++;
      last_active = rdy;
      if (last_active) act++;
      seen = Mem_Success;
    end
    rdy = 1'b1;
    check($sformatf("%s latency", tag), 32'(lat), 32'(v.exp_lat));
    check($sformatf("%s write pulses", tag), 32'(wrs), v.wn ? 32'(k) : 32'd0);
    if (!v.wn) check($sformatf("%s Read_Value", tag), Read_Value, v.exp_val);
    if (v.wn) begin
      for (int i = 0; i < k; i++) begin
        ea = v.addr + 32'(i);
        wd = v.wdata >> (8 * i);
        check($sformatf("%s ram[%0d]", tag, i), 32'(ram[ea[11:0]]), 32'(wd[7:0]));
      end
    end
    tick();
    check($sformatf("%s success one-cycle", tag), 32'(Mem_Success), 32'd0);
  endtask

  initial begin
    vec_t sv;
    logic [31:0] hold_a;
    errors = 0; checks = 0;
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; RN = 1'b0; WN = 1'b0; Addr = '0; Wvalue = '0;
    Width = 2'b00; Sign = 1'b0; io_buffer_full = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    ram[12'h104] = 8'hEF; ram[12'h105] = 8'hBE; ram[12'h106] = 8'hAD; ram[12'h107] = 8'hDE;
    ram[12'h040] = 8'h80; ram[12'h042] = 8'h34; ram[12'h043] = 8'hF2;
    ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;

    //            rn    wn    addr           wdata          w      sgn   exp_val        lat
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         2'b10, 1'b0, 32'h1234_5678, 5};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         2'b00, 1'b1, 32'hFFFF_FF80, 2};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         2'b00, 1'b0, 32'h0000_0080, 2};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h0000_ABCD, 2'b01, 1'b0, 32'h0,         2};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         2'b01, 1'b1, 32'hFFFF_ABCD, 3};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         2'b01, 1'b0, 32'h0000_ABCD, 3};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0,         4};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 5};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         2'b11, 1'b1, 32'hDEAD_BEEF, 5};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0210, 32'h1234_565A, 2'b00, 1'b0, 32'h0,         1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0210, 32'h0,         2'b00, 1'b1, 32'h0000_005A, 2};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0,         2'b10, 1'b0, 32'h4433_2211, 5};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0042, 32'h0,         2'b01, 1'b1, 32'hFFFF_F234, 3};

    tick(); tick();
    check("reset Mem_Success", 32'(Mem_Success), 32'd0);
    check("reset Read_Value", Read_Value, 32'd0);
    check("reset mem_a", mem_a, 32'd0);
    check("reset mem_dout", 32'(mem_dout), 32'd0);
    check("reset mem_wr", 32'(mem_wr), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) run_txn($sformatf("vec%0d", i), vecs[i], -1, 0);

    // clr one cycle after byte 1 of a word read is issued
    RN = 1'b1; Width = 2'b10; Addr = 32'h100; Sign = 1'b0;
    tick();
    RN = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    hold_a = mem_a;
    for (int i = 0; i < 8; i++) begin
      check("clr no success", 32'(Mem_Success), 32'd0);
      check("clr mem_wr", 32'(mem_wr), 32'd0);
      check("clr mem_a frozen", mem_a, hold_a);
      tick();
    end
    sv = '{1'b1, 1'b0, 32'h104, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 5};
    run_txn("after clr", sv, -1, 0);

    // clr in IDLE blocks a read request
    RN = 1'b1; clr = 1'b1; Addr = 32'h40; Width = 2'b00;
    hold_a = mem_a;
    tick();
    RN = 1'b0; clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("idle clr no success", 32'(Mem_Success), 32'd0);
      check("idle clr mem_a", mem_a, hold_a);
      tick();
    end

    // clr during a write does not stop it
    WN = 1'b1; Addr = 32'h230; Wvalue = 32'h0000_7788; Width = 2'b01;
    tick();
    WN = 1'b0; clr = 1'b1;
    tick();
    check("wr clr byte1 mem_wr", 32'(mem_wr), 32'd1);
    tick();
    check("wr clr success", 32'(Mem_Success), 32'd1);
    clr = 1'b0;
    check("wr clr ram0", 32'(ram[12'h230]), 32'h88);
    check("wr clr ram1", 32'(ram[12'h231]), 32'h77);
    tick();

    // IO backpressure
    io_buffer_full = 1'b1;
    WN = 1'b1; Addr = 32'h0003_0000; Wvalue = 32'h0000_00A5; Width = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("io full mem_wr", 32'(mem_wr), 32'd0);
      check("io full success", 32'(Mem_Success), 32'd0);
    end
    io_buffer_full = 1'b0;
    tick();
    WN = 1'b0;
    check("io mem_wr", 32'(mem_wr), 32'd1);
    check("io mem_a", mem_a, 32'h0003_0000);
    check("io mem_dout", 32'(mem_dout), 32'hA5);
    tick();
    check("io success", 32'(Mem_Success), 32'd1);
    check("io mem_wr off", 32'(mem_wr), 32'd0);
    tick();
    io_buffer_full = 1'b1;
    WN = 1'b1; Addr = 32'h0003_0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("io1 full mem_wr", 32'(mem_wr), 32'd0);
    end
    WN = 1'b0; io_buffer_full = 1'b0;
    tick();

    // rdy stalls mid-word
    sv = '{1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 8};
    run_txn("stall read", sv, 2, 3);
    sv = '{1'b0, 1'b1, 32'h300, 32'h1122_3344, 2'b10, 1'b0, 32'h0, 7};
    run_txn("stall write", sv, 1, 3);
    sv = '{1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 32'h1122_3344, 5};
    run_txn("stall readback", sv, -1, 0);

    // reset in the middle of a write
    WN = 1'b1; Addr = 32'h400; Wvalue = 32'h9988_7766; Width = 2'b10;
    tick();
    WN = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst mid Mem_Success", 32'(Mem_Success), 32'd0);
    check("rst mid mem_wr", 32'(mem_wr), 32'd0);
    check("rst mid mem_a", mem_a, 32'd0);
    check("rst mid mem_dout", 32'(mem_dout), 32'd0);
    check("rst mid Read_Value", Read_Value, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst mid no success", 32'(Mem_Success), 32'd0);
      check("rst mid no write", 32'(mem_wr), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Responder side of the ROB memory interface. It accepts one load or store request at a time (RN/WN with Addr/Wvalue), serialises it into byte accesses on the 8-bit synchronous RAM/IO port, assembles and sign-extends load data, and returns a single-cycle Mem_Success pulse with Read_Value. It sits between the ROB and the top-level RAM/IO bus.

Parameters:
ADDR_W, 32, width of Addr and mem_a
IO_ADDR0, 32'h30000, IO write port address subject to io_buffer_full backpressure
IO_ADDR1, 32'h30004, second IO address subject to backpressure

Ports:
clk  input  1  system clock
rst  input  1  reset
rdy  input  1  global ready; low freezes the block
clr  input  1  flush from Flow_Control; aborts an in-flight read
RN  input  1  read request
WN  input  1  write request; wins if RN is also high
Addr  input  ADDR_W  byte address of the access
Wvalue  input  32  store data; low bytes are used first
Width  input  2  access width: 00 byte, 01 half, 10 word
Sign  input  1  sign-extend loads when 1 (LB/LH); zero-extend when 0
Mem_Success  output  1  one-cycle completion pulse
Read_Value  output  32  assembled load result; valid while Mem_Success is high
mem_din  input  8  RAM/IO read byte
mem_dout  output  8  RAM/IO write byte
mem_a  output  ADDR_W  RAM/IO byte address
mem_wr  output  1  1 = write strobe, 0 = read
io_buffer_full  input  1  IO FIFO full; blocks writes to IO_ADDR0/IO_ADDR1

Behaviour:
- Reset (rst, synchronous, active-high; clock clk) values: state IDLE; Mem_Success=0; Read_Value=0; mem_a=0; mem_dout=0; mem_wr=0; byte counters=0.
- A reset asserted mid-operation discards the access; no Success is produced.
- States: IDLE, READ, WRITE, DONE.
- Byte count k: 1, 2 or 4 from Width. Width 11 is treated as word.
- Byte i address is Addr+i, computed modulo 2^ADDR_W.
- IDLE, request accepted at edge T when rdy=1 and RN or WN is high:
  - If WN=1, Addr equals IO_ADDR0 or IO_ADDR1, and io_buffer_full=1: the request is not accepted; stay in IDLE with mem_wr=0.
  - Otherwise, latch Addr, Wvalue, Width and Sign, then go to WRITE (if WN=1) or READ.
- RAM timing: mem_a is sampled at an edge; mem_din is valid during the following cycle.
- READ:
  - After edge T+i (i<k): mem_a=Addr+i, mem_wr=0.
  - Byte i is captured from mem_din at edge T+i+2.
  - At edge T+k+1: Read_Value = assembled little-endian bytes, sign- or zero-extended from bit 8k-1. Mem_Success=1; go to DONE.
- WRITE:
  - After edge T+i (i<k): mem_a=Addr+i, mem_dout=Wvalue[8i+7:8i], mem_wr=1.
  - At edge T+k: mem_wr=0, Mem_Success=1; go to DONE.
- DONE: lasts exactly one cycle. Mem_Success returns to 0 and the state returns to IDLE. Requests are ignored in DONE.
- Requester obligation: RN/WN must be dropped or replaced in the cycle Mem_Success is high. Otherwise it is accepted again as a new access.
- mem_wr is 0 in every state other than WRITE.
- Resulting latency, accept to Success: word read 5 edges, word write 4 edges, byte read 2 edges, byte write 1 edge.
- clr:
  - Aborts READ or a pending IDLE read: go to IDLE, no Success, mem_wr=0.
  - WRITE continues to completion, because stores are committed.
  - clr in IDLE blocks acceptance of RN that cycle.
- rdy=0:
  - All state, counters and outputs are held, except mem_wr, which is forced to 0 so no byte is written twice.
  - Capture timing is re-based: the pipeline resumes after rdy returns to 1. The block re-issues the current mem_a so the capture stays aligned.
- Simultaneous RN and WN: the write is serviced and RN is ignored.

Decomposition:
- Shared constants.v:
  - width encodings `MEM_B/`MEM_H/`MEM_W
  - state encodings `MC_IDLE/`MC_READ/`MC_WRITE/`MC_DONE
  - `IO_ADDR0/`IO_ADDR1
  - existing `True/`False
- No sub-module. Byte assembly and extension is a single combinational function inside mem_ctrl.

Test Plan:
1. RAM[0x100..0x103]=78 56 34 12; RN, Width=10, Addr=0x100 → mem_a steps 0x100..0x103, mem_wr=0; Mem_Success high for 1 cycle, 5 edges after accept; Read_Value=0x12345678.
2. RAM[0x40]=0x80; LB (Sign=1) → Read_Value=0xFFFFFF80; LBU (Sign=0) → 0x00000080; each Success 2 edges after accept.
3. WN, Width=01, Addr=0x200, Wvalue=0x0000ABCD → (0x200,CD,wr=1) then (0x201,AB,wr=1); Success after 2 edges; RAM holds CD AB.
4. Word read to 0x100 with clr asserted the cycle after byte 1 is issued → no Mem_Success, state IDLE, mem_wr=0; next RN to 0x104 returns correct data.
5. SB to 0x30000 with io_buffer_full=1 for 6 cycles → mem_wr=0 throughout; full drops → one write of Wvalue[7:0] to 0x30000, Success next cycle.
6. rdy=0 for 3 cycles mid-word-read and mid-word-write → no duplicate mem_wr pulses, results unchanged, latency stretched by exactly 3; rst mid-write → all outputs 0, no Success.
